// File: rtl/conv_mac_lanes.sv
// conv_mac_lanes: multi-lane signed multiply-accumulate for one convolution
// window per result. Pipeline: input capture (p0), lane products (p1),
// lane sum (p2), then accumulate and result load. A stalled output freezes
// the whole pipeline, so no accepted beat is lost or duplicated.
module conv_mac_lanes #(
    parameter int DATA_W = 16,
    parameter int FILT_W = 4,
    parameter int LANES  = 4,
    parameter int ACC_W  = 32,
    parameter int SHIFT  = 0,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_image,
    input  logic [LANES*FILT_W-1:0]   in_filter,
    input  logic [LANES-1:0]          in_mask,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_sat,
    output logic [CNT_W-1:0]          out_count
);

    localparam int PROD_W = DATA_W + FILT_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);

    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // The accumulator sum carries one guard bit; differing top bits mean overflow.
    function automatic logic acc_clipped(input logic signed [ACC_W:0] v);
        return v[ACC_W] ^ v[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
        if (v[ACC_W] ^ v[ACC_W-1])
            return v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return v[ACC_W-1:0];
    endfunction

    function automatic logic out_clipped(input logic signed [ACC_W-1:0] v);
        return (v > OUT_MAX) || (v < OUT_MIN);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        if (v > OUT_MAX)
            return {1'b0, {(DATA_W-1){1'b1}}};
        if (v < OUT_MIN)
            return {1'b1, {(DATA_W-1){1'b0}}};
        return v[DATA_W-1:0];
    endfunction

    logic                      w_stall;
    logic                      w_accept;

    logic                      r_vld_p0;
    logic                      r_last_p0;
    logic [LANES-1:0]          r_mask_p0;
    logic signed [DATA_W-1:0]  r_img_p0 [LANES];
    logic signed [FILT_W-1:0]  r_flt_p0 [LANES];

    logic signed [PROD_W-1:0]  w_prod [LANES];
    logic                      r_vld_p1;
    logic                      r_last_p1;
    logic signed [PROD_W-1:0]  r_prod_p1 [LANES];

    logic signed [SUM_W-1:0]   w_lanesum;
    logic                      r_vld_p2;
    logic                      r_last_p2;
    logic signed [SUM_W-1:0]   r_sum_p2;

    logic signed [ACC_W:0]     w_acc_ext;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [ACC_W-1:0]   w_shifted;
    logic                      w_acc_clip;
    logic                      w_out_clip;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_sticky;
    logic [CNT_W-1:0]          r_cnt;

    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;
    assign w_accept = in_valid & ~w_stall;

    // ---- stage p0: capture accepted beat ----
    // Valid for the captured beat; a stall freezes it.
    always_ff @(posedge clk) begin
        if (reset)
            r_vld_p0 <= 1'b0;
        else if (!w_stall)
            r_vld_p0 <= in_valid;
    end

    // Beat payload loads only on accept, so idle-bus values never enter.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_last_p0 <= in_last;
            r_mask_p0 <= in_mask;
            for (int i = 0; i < LANES; i++) begin
                r_img_p0[i] <= $signed(in_image[i*DATA_W +: DATA_W]);
                r_flt_p0[i] <= $signed(in_filter[i*FILT_W +: FILT_W]);
            end
        end
    end

    // ---- stage p1: masked full-precision lane products ----
    // Masked-off lanes contribute zero.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_prod[i] = '0;
            if (r_mask_p0[i])
                w_prod[i] = PROD_W'(r_img_p0[i]) * PROD_W'(r_flt_p0[i]);
        end
    end

    // Product valid register.
    always_ff @(posedge clk) begin
        if (reset)
            r_vld_p1 <= 1'b0;
        else if (!w_stall)
            r_vld_p1 <= r_vld_p0;
    end

    // Product data register.
    always_ff @(posedge clk) begin
        if (!w_stall && r_vld_p0) begin
            r_last_p1 <= r_last_p0;
            for (int i = 0; i < LANES; i++)
                r_prod_p1[i] <= w_prod[i];
        end
    end

    // ---- stage p2: lane sum, widened so it cannot overflow ----
    // Adder tree over all lanes.
    always_comb begin
        w_lanesum = '0;
        for (int i = 0; i < LANES; i++)
            w_lanesum = w_lanesum + SUM_W'(r_prod_p1[i]);
    end

    // Lane-sum valid register.
    always_ff @(posedge clk) begin
        if (reset)
            r_vld_p2 <= 1'b0;
        else if (!w_stall)
            r_vld_p2 <= r_vld_p1;
    end

    // Lane-sum data register.
    always_ff @(posedge clk) begin
        if (!w_stall && r_vld_p1) begin
            r_last_p2 <= r_last_p1;
            r_sum_p2  <= w_lanesum;
        end
    end

    // ---- stage 3: accumulate, post-shift, output saturation ----
    // Saturating accumulate and final scaling of the window result.
    always_comb begin
        w_acc_ext  = {r_acc[ACC_W-1], r_acc} + (ACC_W+1)'(r_sum_p2);
        w_acc_clip = acc_clipped(w_acc_ext);
        w_acc_next = sat_acc(w_acc_ext);
        w_shifted  = w_acc_next >>> SHIFT;
        w_out_clip = out_clipped(w_shifted);
    end

    // Window state: accumulator, sticky clip flag and beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (!w_stall && r_vld_p2) begin
            if (r_last_p2) begin
                r_acc    <= '0;
                r_sticky <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_acc    <= w_acc_next;
                r_sticky <= r_sticky | w_acc_clip;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Result register; a completing window reloads it even while the old one drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_count <= '0;
        end else if (!w_stall) begin
            if (r_vld_p2 && r_last_p2) begin
                out_valid <= 1'b1;
                out_data  <= sat_out(w_shifted);
                out_sat   <= r_sticky | w_acc_clip | w_out_clip;
                out_count <= r_cnt + CNT_W'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_lanes.sv
// Directed testbench for conv_mac_lanes: default instance plus a SHIFT=4 instance.
module tb_conv_mac_lanes;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_image;
    logic [15:0] in_filter;
    logic [3:0]  in_mask;
    logic        in_last;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_sat;
    logic [15:0] out_data;
    logic [7:0]  out_count;
    logic        in_ready2, out_valid2, out_sat2;
    logic [15:0] out_data2;
    logic [7:0]  out_count2;

    always #5 clk = ~clk;

    conv_mac_lanes #(.DATA_W(16), .FILT_W(4), .LANES(4), .ACC_W(32), .SHIFT(0), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_image(in_image), .in_filter(in_filter), .in_mask(in_mask), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .out_count(out_count)
    );

    conv_mac_lanes #(.DATA_W(16), .FILT_W(4), .LANES(4), .ACC_W(32), .SHIFT(4), .CNT_W(8)) dut_sh (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_image(in_image), .in_filter(in_filter), .in_mask(in_mask), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_sat(out_sat2), .out_count(out_count2)
    );

    typedef struct packed {
        logic signed [15:0] d;
        logic               s;
        logic [7:0]         c;
    } res_t;

    res_t q1[$];
    res_t q2[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Capture every handshaken result, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready)
            q1.push_back({out_data, out_sat, out_count});
        if (!reset && out_valid2 && out_ready)
            q2.push_back({out_data2, out_sat2, out_count2});
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pk_img(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic logic [15:0] pk_flt(input int a, input int b, input int c, input int d);
        return {d[3:0], c[3:0], b[3:0], a[3:0]};
    endfunction

    // Present one beat and hold it until the DUT accepts it.
    task automatic send(input logic [63:0] img, input logic [15:0] flt,
                        input logic [3:0] mask, input logic last);
        int n = 0;
        bit took = 1'b0;
        in_image  = img;
        in_filter = flt;
        in_mask   = mask;
        in_last   = last;
        in_valid  = 1'b1;
        do begin
            took = in_ready;
            next_cycle();
            n++;
        end while (!took && n < 300);
        if (!took)
            check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a result of the chosen instance and compare all fields.
    task automatic expect_res(input string tag, input bit shifted_dut,
                              input int d, input int s, input int c);
        int   n = 0;
        res_t r;
        while ((shifted_dut ? q2.size() : q1.size()) == 0 && n < 60) begin
            next_cycle();
            n++;
        end
        if ((shifted_dut ? q2.size() : q1.size()) == 0) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            r = shifted_dut ? q2.pop_front() : q1.pop_front();
            check({tag, "_data"}, r.d, d);
            check({tag, "_sat"}, r.s, s);
            check({tag, "_count"}, r.c, c);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_image  = '0;
        in_filter = '0;
        in_mask   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) next_cycle();
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_count", out_count, 0);
        check("rst_in_ready", in_ready, 1);

        // Test 1: single beat, latency of 3 edges after acceptance.
        send(pk_img(1, 2, 3, 4), pk_flt(1, 1, 1, 1), 4'b1111, 1'b1);
        next_cycle();
        next_cycle();
        check("t1_valid_early", out_valid, 0);
        next_cycle();
        check("t1_valid_lat3", out_valid, 1);
        expect_res("t1", 1'b0, 10, 0, 1);

        // Test 2: three-beat window with partial mask, then output clipping.
        send(pk_img(100, 100, 100, 100), pk_flt(2, 2, 2, 2), 4'b1111, 1'b0);
        send(pk_img(100, 100, 100, 100), pk_flt(2, 2, 2, 2), 4'b1111, 1'b0);
        send(pk_img(100, 100, 100, 100), pk_flt(2, 2, 2, 2), 4'b0011, 1'b1);
        expect_res("t2a", 1'b0, 2000, 0, 3);
        send(pk_img(-32768, -32768, -32768, -32768), pk_flt(-8, -8, -8, -8), 4'b0001, 1'b1);
        expect_res("t2b", 1'b0, 32767, 1, 1);

        // Test 3: positive and negative full-scale windows.
        send(pk_img(32767, 32767, 32767, 32767), pk_flt(7, 7, 7, 7), 4'b1111, 1'b0);
        send(pk_img(32767, 32767, 32767, 32767), pk_flt(7, 7, 7, 7), 4'b1111, 1'b1);
        expect_res("t3pos", 1'b0, 32767, 1, 2);
        send(pk_img(32767, 32767, 32767, 32767), pk_flt(-8, -8, -8, -8), 4'b1111, 1'b0);
        send(pk_img(32767, 32767, 32767, 32767), pk_flt(-8, -8, -8, -8), 4'b1111, 1'b1);
        expect_res("t3neg", 1'b0, -32768, 1, 2);

        // Test 4: SHIFT=4 instance, arithmetic shift rounds toward minus infinity.
        q1.delete();
        q2.delete();
        send(pk_img(160, 0, 0, 0), pk_flt(1, 0, 0, 0), 4'b1111, 1'b1);
        expect_res("t4pos", 1'b1, 10, 0, 1);
        send(pk_img(-17, 0, 0, 0), pk_flt(1, 0, 0, 0), 4'b1111, 1'b1);
        expect_res("t4neg", 1'b1, -2, 0, 1);
        next_cycle();
        q1.delete();

        // Test 5: backpressure while window B streams behind window A.
        out_ready = 1'b0;
        fork
            begin
                send(pk_img(10, 0, 0, 0), pk_flt(1, 0, 0, 0), 4'b0001, 1'b1);
                send(pk_img(5, 0, 0, 0), pk_flt(1, 0, 0, 0), 4'b0001, 1'b0);
                send(pk_img(5, 0, 0, 0), pk_flt(1, 0, 0, 0), 4'b0001, 1'b0);
                send(pk_img(5, 0, 0, 0), pk_flt(1, 0, 0, 0), 4'b0001, 1'b0);
                send(pk_img(5, 0, 0, 0), pk_flt(1, 0, 0, 0), 4'b0001, 1'b1);
            end
        join_none
        n = 0;
        while (!out_valid && n < 50) begin
            next_cycle();
            n++;
        end
        check("t5_a_valid", out_valid, 1);
        for (int k = 0; k < 4; k++) begin
            check("t5_stall_in_ready", in_ready, 0);
            check("t5_stall_data", $signed(out_data), 10);
            check("t5_stall_valid", out_valid, 1);
            next_cycle();
        end
        out_ready = 1'b1;
        expect_res("t5a", 1'b0, 10, 0, 1);
        expect_res("t5b", 1'b0, 20, 0, 4);
        repeat (3) next_cycle();

        // Back-to-back single-beat windows: no out_valid gap.
        q1.delete();
        send(pk_img(10, 0, 0, 0), pk_flt(1, 0, 0, 0), 4'b0001, 1'b1);
        send(pk_img(20, 0, 0, 0), pk_flt(1, 0, 0, 0), 4'b0001, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            next_cycle();
            n++;
        end
        check("t5_b2b_first", $signed(out_data), 10);
        next_cycle();
        check("t5_b2b_valid", out_valid, 1);
        check("t5_b2b_second", $signed(out_data), 20);
        next_cycle();
        check("t5_b2b_drain", out_valid, 0);
        q1.delete();
        q2.delete();

        // Test 6: reset in the middle of a window discards it.
        send(pk_img(5, 0, 0, 0), pk_flt(1, 0, 0, 0), 4'b0001, 1'b0);
        send(pk_img(5, 0, 0, 0), pk_flt(1, 0, 0, 0), 4'b0001, 1'b0);
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        check("t6_in_ready", in_ready, 1);
        check("t6_valid_cleared", out_valid, 0);
        repeat (6) next_cycle();
        check("t6_no_stale", q1.size(), 0);
        send(pk_img(3, 0, 0, 0), pk_flt(1, 0, 0, 0), 4'b0001, 1'b1);
        expect_res("t6", 1'b0, 3, 0, 1);
        repeat (6) next_cycle();
        check("t6_no_extra", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
